// File: rtl/cpu_io_bridge.sv
// Host-side GPIO bridge: host writes drive core io0/io1; io2 (and optionally io3) value changes
// are captured into a first-word fall-through FIFO. Optional io3 capture: CPU_IO_BRIDGE_IO3_CAPTURE_EN.
module cpu_io_bridge #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         cpu_io2,
    input  logic [WIDTH-1:0]         cpu_io3,
    output logic [WIDTH-1:0]         cpu_io0,
    output logic [WIDTH-1:0]         cpu_io1,
    input  logic                     host_wr_valid,
    output logic                     host_wr_ready,
    input  logic                     host_wr_sel,
    input  logic [WIDTH-1:0]         host_wr_data,
    output logic                     host_rd_valid,
    input  logic                     host_rd_ready,
    output logic [WIDTH-1:0]         host_rd_data,
    output logic                     host_rd_tag,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_data [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic [WIDTH-1:0] prev_io2;
    logic [WIDTH-1:0] io0_q;
    logic [WIDTH-1:0] io1_q;
    logic             ready_q;
    logic             overflow_q;

    logic             push;
    logic             pop;
    logic             full;
    logic             push_ok;
    logic             drop;
    logic [WIDTH-1:0] push_data;

    assign full    = (level_q == LW'(DEPTH));
    assign pop     = (level_q != '0) && host_rd_ready;
    // a full FIFO still accepts a push when the head leaves on the same edge
    assign push_ok = push && (!full || pop);

`ifdef CPU_IO_BRIDGE_IO3_CAPTURE_EN
    logic             mem_tag [DEPTH];
    logic [WIDTH-1:0] prev_io3;
    logic [WIDTH-1:0] pend_data;
    logic             pend_valid;
    logic             pend_set;
    logic             push_tag;

    // priority: pending slot, then io2 change, then io3 change; only io3 can wait in the slot
    always_comb begin
        push      = 1'b0;
        push_tag  = 1'b0;
        push_data = '0;
        drop      = 1'b0;
        pend_set  = 1'b0;
        if (pend_valid) begin
            push      = 1'b1;
            push_tag  = 1'b1;
            push_data = pend_data;
            drop      = (cpu_io2 != prev_io2) || (cpu_io3 != prev_io3);
        end else if (cpu_io2 != prev_io2) begin
            push      = 1'b1;
            push_data = cpu_io2;
            pend_set  = (cpu_io3 != prev_io3);
        end else if (cpu_io3 != prev_io3) begin
            push      = 1'b1;
            push_tag  = 1'b1;
            push_data = cpu_io3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_io3   <= '0;
            pend_valid <= 1'b0;
            pend_data  <= '0;
        end else begin
            prev_io3   <= cpu_io3;
            pend_valid <= pend_set;
            if (pend_set) pend_data <= cpu_io3;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_tag[wr_ptr] <= push_tag;
    end

    assign host_rd_tag = (level_q != '0) ? mem_tag[rd_ptr] : 1'b0;
`else
    logic io3_unused;
    assign io3_unused = ^cpu_io3;

    always_comb begin
        push      = (cpu_io2 != prev_io2);
        push_data = cpu_io2;
        drop      = 1'b0;
    end

    assign host_rd_tag = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q    <= 1'b0;
            io0_q      <= '0;
            io1_q      <= '0;
            prev_io2   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            ready_q  <= 1'b1;
            prev_io2 <= cpu_io2;
            if (host_wr_valid && ready_q) begin
                if (host_wr_sel) io1_q <= host_wr_data;
                else             io0_q <= host_wr_data;
            end
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      level_q <= level_q + 1'b1;
            else if (!push_ok && pop) level_q <= level_q - 1'b1;
            if (drop || (push && !push_ok)) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_data[wr_ptr] <= push_data;
    end

    assign cpu_io0       = io0_q;
    assign cpu_io1       = io1_q;
    assign host_wr_ready = ready_q;
    assign host_rd_valid = (level_q != '0);
    assign host_rd_data  = (level_q != '0) ? mem_data[rd_ptr] : '0;
    assign overflow      = overflow_q;
    assign level         = level_q;

endmodule

// File: doc/cpu_io_bridge.md
Name: cpu_io_bridge

Overview:
- Host-side counterpart of the core's memory-mapped GPIO ports.
- Drives the core's two input ports (io0/io1) from host writes, using a valid/ready handshake.
- Watches the core's output ports (io2, and optionally io3), which have no write strobe. Every value change is captured into a FIFO that the host drains with a valid/ready handshake.
- Sits at top level between `cpu` and a test host or external controller.

Parameters:
- DEPTH, 8, number of FIFO entries; power of 2, minimum 2
- WIDTH, 32, GPIO data width; must match the core's io width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_io2  in  WIDTH  from core io2_out
- cpu_io3  in  WIDTH  from core io3_out
- cpu_io0  out  WIDTH  to core io0_in
- cpu_io1  out  WIDTH  to core io1_in
- host_wr_valid  in  1  host write request
- host_wr_ready  out  1  bridge accepts write
- host_wr_sel  in  1  write target: 0 = io0, 1 = io1
- host_wr_data  in  WIDTH  write value
- host_rd_valid  out  1  FIFO head valid
- host_rd_ready  in  1  host pops head
- host_rd_data  out  WIDTH  head value
- host_rd_tag  out  1  head source: 0 = io2, 1 = io3
- overflow  out  1  sticky: a change was dropped
- level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset, asynchronous, effective immediately:
  - cpu_io0, cpu_io1, host_rd_data, level = 0
  - host_rd_valid, host_wr_ready, overflow = 0
  - FIFO pointers cleared; prev_io2/prev_io3 = 0; pending slot empty
- Reset mid-operation discards all FIFO contents and any in-flight write.
- Write port:
  - host_wr_ready is 0 during reset and for the first cycle after rst_n rises; it is 1 thereafter.
  - A write is accepted on an edge where valid && ready. The selected output takes host_wr_data on that edge and is visible after it.
  - Unselected output holds its value. Back-to-back writes are allowed, one per cycle.
- Change detection:
  - Each edge compares cpu_io2 to prev_io2. prev_io2 is updated every edge, unconditionally.
  - Inequality produces a push of {tag=0, cpu_io2} on the same edge.
  - The entry is visible on host_rd_* after that edge, giving 1-cycle latency from the input being sampled.
  - Because prev resets to 0, a first value of 0 creates no entry.
- FIFO:
  - First-word fall-through. host_rd_valid = (level != 0).
  - host_rd_data/tag show the head entry; both are 0 when empty.
  - Pop occurs on an edge where valid && ready. A pop when empty is ignored.
  - Push when full (and no simultaneous pop): entry dropped, overflow set to 1. overflow clears only on reset.
  - Simultaneous push and pop when full: both happen, level unchanged, no overflow.
  - Pointers wrap modulo DEPTH. level ranges 0..DEPTH.
- At most one push per edge.

Optional Feature:
- Macro: CPU_IO_BRIDGE_IO3_CAPTURE_EN.
- Defined:
  - cpu_io3 changes are detected the same way, using prev_io3, and push {tag=1, cpu_io3}.
  - Push arbitration order per edge: pending slot > io2 change > io3 change.
  - A losing io3 change goes into a one-entry pending slot and is pushed on the next edge.
  - A change that loses arbitration while the pending slot is occupied is dropped and sets overflow.
  - The pending slot is not counted in level.
- Undefined:
  - cpu_io3 is ignored and there is no pending slot.
  - host_rd_tag is tied to 0.

Test Plan:
- Reset, then 2 idle cycles with cpu_io2 held at 0 → host_rd_valid=0, level=0, overflow=0, host_wr_ready=1 from the 2nd cycle after reset release.
- Host writes sel=0, data 0x1234 and then sel=1, data 0xABCD on consecutive cycles → cpu_io0=0x1234 one edge after the first write; cpu_io1=0xABCD one edge after the second; cpu_io0 unchanged.
- cpu_io2 steps 0→5→5→9 on successive edges with host_rd_ready=0 → level=2; pops return 5 then 9, both with tag 0.
- 9 distinct cpu_io2 values with DEPTH=8 and no pops → level=8, overflow=1; popping yields the first 8 values. Then a push and pop on the same edge → level stays 8, overflow stays 1.
- With the feature enabled: cpu_io2 changes to 0x11 and cpu_io3 to 0x22 on the same edge → entries {0,0x11} then {1,0x22} on consecutive edges, overflow=0. Without the feature: only {0,0x11}.
- Assert rst_n low mid-stream with level=3 → all outputs 0 immediately. After release, the old contents never appear.
